// File: rtl/matmul_seq_if.sv
// Control bundle between the register file (master) and the matmul sequencer (slave).
// Signal names carry the sequencer's port directions.
interface matmul_seq_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int SP_NTARGETS = 4
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int FW      = $clog2(3 * MAX_DIM);
  localparam int TW      = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;

  logic          start_i;
  logic          mode_i;
  logic [DW-1:0] dim_n_i;
  logic [DW-1:0] dim_k_i;
  logic [DW-1:0] dim_m_i;
  logic [TW-1:0] wr_target_i;
  logic [TW-1:0] rd_target_i;
  logic          busy_o;
  logic          done_o;
  logic          pe_clear_o;
  logic          feed_en_o;
  logic [FW-1:0] feed_idx_o;
  logic          sp_rd_en_o;
  logic [DW-1:0] sp_rd_row_o;
  logic          bias_ld_o;
  logic [DW-1:0] bias_row_o;
  logic          sp_wr_en_o;
  logic [DW-1:0] sp_wr_row_o;
  logic [TW-1:0] sp_target_o;

  modport master (
    output start_i, mode_i, dim_n_i, dim_k_i, dim_m_i, wr_target_i, rd_target_i,
    input  busy_o, done_o, pe_clear_o, feed_en_o, feed_idx_o, sp_rd_en_o, sp_rd_row_o,
           bias_ld_o, bias_row_o, sp_wr_en_o, sp_wr_row_o, sp_target_o
  );

  modport slave (
    input  start_i, mode_i, dim_n_i, dim_k_i, dim_m_i, wr_target_i, rd_target_i,
    output busy_o, done_o, pe_clear_o, feed_en_o, feed_idx_o, sp_rd_en_o, sp_rd_row_o,
           bias_ld_o, bias_row_o, sp_wr_en_o, sp_wr_row_o, sp_target_o
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the systolic PE array: clear or bias load, skewed feed, row-wise C write-back.
// Optional bias-accumulate path is compiled in with `define MATMUL_SEQ_BIAS_EN.
module matmul_seq_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int SP_NTARGETS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  matmul_seq_if.slave ctl
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int FW      = $clog2(3 * MAX_DIM);
  localparam int TW      = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;

  localparam logic [FW-1:0] CNT_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] CNT_ONE  = FW'(1'b1);
  localparam logic [DW-1:0] ROW_ZERO = {DW{1'b0}};
  localparam logic [TW-1:0] TGT_ZERO = {TW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
`ifdef MATMUL_SEQ_BIAS_EN
    ,ST_BIAS = 3'd5
`endif
  } state_e;

  state_e        state_r, state_nxt_s;
  logic [FW-1:0] cnt_r, cnt_nxt_s;
  logic [DW-1:0] dim_n_r, dim_k_r, dim_m_r;
  logic [TW-1:0] wr_tgt_r;
  logic          armed_r;
  logic          accept_s;
  logic [FW-1:0] feed_last_s;

  logic          busy_s, done_s, clear_s, feed_en_s, rd_en_s, ld_s, wr_en_s;
  logic [FW-1:0] feed_idx_s;
  logic [DW-1:0] rd_row_s, bias_row_s, wr_row_s;
  logic [TW-1:0] tgt_s;

  logic          busy_r, done_r, clear_r, feed_en_r, rd_en_r, ld_r, wr_en_r;
  logic [FW-1:0] feed_idx_r;
  logic [DW-1:0] rd_row_r, bias_row_r, wr_row_r;
  logic [TW-1:0] tgt_r;

`ifdef MATMUL_SEQ_BIAS_EN
  logic [TW-1:0] rd_tgt_r;
  logic [DW-1:0] n_sel_s;
  logic [TW-1:0] rd_tgt_sel_s;
  logic [FW-1:0] bias_idx_s;
  // The first BIAS cycle is decoded on the accept edge, before the latches hold the new run.
  assign n_sel_s      = accept_s ? ctl.dim_n_i : dim_n_r;
  assign rd_tgt_sel_s = accept_s ? ctl.rd_target_i : rd_tgt_r;
  assign bias_idx_s   = cnt_nxt_s - CNT_ONE;
`else
  logic unused_s;
  assign unused_s = ^{ctl.mode_i, ctl.rd_target_i};
`endif

  // Skewed feed needs k+n+m-2 steps; the last index equals the sum of the minus-one dims.
  assign feed_last_s = FW'(dim_k_r) + FW'(dim_n_r) + FW'(dim_m_r);

  // Start is edge-armed: once accepted, it must be seen low before it can start another run.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == ST_IDLE) && ctl.start_i && armed_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // State and step-counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Run-parameter capture and start re-arm tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dim_n_r  <= ROW_ZERO;
      dim_k_r  <= ROW_ZERO;
      dim_m_r  <= ROW_ZERO;
      wr_tgt_r <= TGT_ZERO;
`ifdef MATMUL_SEQ_BIAS_EN
      rd_tgt_r <= TGT_ZERO;
`endif
      armed_r  <= 1'b1;
    end else begin
      if (accept_s) begin
        dim_n_r  <= ctl.dim_n_i;
        dim_k_r  <= ctl.dim_k_i;
        dim_m_r  <= ctl.dim_m_i;
        wr_tgt_r <= ctl.wr_target_i;
`ifdef MATMUL_SEQ_BIAS_EN
        rd_tgt_r <= ctl.rd_target_i;
`endif
        armed_r  <= 1'b0;
      end else if (!ctl.start_i) begin
        armed_r  <= 1'b1;
      end else begin
        armed_r  <= armed_r;
      end
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (accept_s) begin
`ifdef MATMUL_SEQ_BIAS_EN
          state_nxt_s = ctl.mode_i ? ST_BIAS : ST_CLEAR;
`else
          state_nxt_s = ST_CLEAR;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef MATMUL_SEQ_BIAS_EN
      ST_BIAS: begin
        // n read cycles plus one trailing load cycle for the read latency.
        if (cnt_r == (FW'(dim_n_r) + CNT_ONE)) begin
          state_nxt_s = ST_FEED;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
`endif
      ST_CLEAR: begin
        state_nxt_s = ST_FEED;
        cnt_nxt_s   = CNT_ZERO;
      end
      ST_FEED: begin
        if (cnt_r == feed_last_s) begin
          state_nxt_s = ST_WRITE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_WRITE: begin
        if (cnt_r == FW'(dim_n_r)) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    busy_s     = 1'b0;
    done_s     = 1'b0;
    clear_s    = 1'b0;
    feed_en_s  = 1'b0;
    feed_idx_s = CNT_ZERO;
    rd_en_s    = 1'b0;
    rd_row_s   = ROW_ZERO;
    ld_s       = 1'b0;
    bias_row_s = ROW_ZERO;
    wr_en_s    = 1'b0;
    wr_row_s   = ROW_ZERO;
    tgt_s      = TGT_ZERO;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
`ifdef MATMUL_SEQ_BIAS_EN
      ST_BIAS: begin
        busy_s = 1'b1;
        if (cnt_nxt_s <= FW'(n_sel_s)) begin
          rd_en_s  = 1'b1;
          rd_row_s = cnt_nxt_s[DW-1:0];
          tgt_s    = rd_tgt_sel_s;
        end else begin
          rd_en_s  = 1'b0;
        end
        if (cnt_nxt_s != CNT_ZERO) begin
          ld_s       = 1'b1;
          bias_row_s = bias_idx_s[DW-1:0];
        end else begin
          ld_s       = 1'b0;
        end
      end
`endif
      ST_CLEAR: begin
        busy_s  = 1'b1;
        clear_s = 1'b1;
      end
      ST_FEED: begin
        busy_s     = 1'b1;
        feed_en_s  = 1'b1;
        feed_idx_s = cnt_nxt_s;
      end
      ST_WRITE: begin
        busy_s   = 1'b1;
        wr_en_s  = 1'b1;
        wr_row_s = cnt_nxt_s[DW-1:0];
        tgt_s    = wr_tgt_r;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      clear_r    <= 1'b0;
      feed_en_r  <= 1'b0;
      feed_idx_r <= CNT_ZERO;
      rd_en_r    <= 1'b0;
      rd_row_r   <= ROW_ZERO;
      ld_r       <= 1'b0;
      bias_row_r <= ROW_ZERO;
      wr_en_r    <= 1'b0;
      wr_row_r   <= ROW_ZERO;
      tgt_r      <= TGT_ZERO;
    end else begin
      busy_r     <= busy_s;
      done_r     <= done_s;
      clear_r    <= clear_s;
      feed_en_r  <= feed_en_s;
      feed_idx_r <= feed_idx_s;
      rd_en_r    <= rd_en_s;
      rd_row_r   <= rd_row_s;
      ld_r       <= ld_s;
      bias_row_r <= bias_row_s;
      wr_en_r    <= wr_en_s;
      wr_row_r   <= wr_row_s;
      tgt_r      <= tgt_s;
    end
  end

  assign ctl.busy_o      = busy_r;
  assign ctl.done_o      = done_r;
  assign ctl.pe_clear_o  = clear_r;
  assign ctl.feed_en_o   = feed_en_r;
  assign ctl.feed_idx_o  = feed_idx_r;
  assign ctl.sp_rd_en_o  = rd_en_r;
  assign ctl.sp_rd_row_o = rd_row_r;
  assign ctl.bias_ld_o   = ld_r;
  assign ctl.bias_row_o  = bias_row_r;
  assign ctl.sp_wr_en_o  = wr_en_r;
  assign ctl.sp_wr_row_o = wr_row_r;
  assign ctl.sp_target_o = tgt_r;
endmodule
